cmos_pair_deadtime_ctrl: RTL and testbench
==========================================

Name: cmos_pair_deadtime_ctrl

Overview:
- Drives the gates of a switch-level CMOS output pair: PMOS pull-up to vdd and NMOS pull-down to gnd.
- The two gates are driven separately rather than tied, so the controller can enforce break-before-make.
- Both devices are never on in the same cycle, and a programmable dead time keeps both off between handovers.
- Sits between digital control logic and the nmos/pmos primitive stage; the shared output net is the resource being sequenced.

Parameters:
- DT_W, 4, width of the dead_time input (dead time up to 2^DT_W-1 cycles)
- CNT_W, 8, width of the transition counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  1 = drive the output per req; 0 = both devices off (output floats)
- req  input  1  requested output level: 1 = pull high via PMOS, 0 = pull low via NMOS
- dead_time  input  DT_W  break-before-make interval in cycles; sampled when a dead interval starts
- pg_n  output  1  PMOS gate; 0 = PMOS on
- ng  output  1  NMOS gate; 1 = NMOS on
- state  output  3  current FSM state code
- busy  output  1  1 while in a dead interval
- trans_cnt  output  CNT_W  number of completed turn-ons; wraps modulo 2^CNT_W

Behaviour:
- Reset, synchronous, active-high. Whatever the previous state, after the reset edge:
  - state=OFF, pg_n=1, ng=0, busy=0, trans_cnt=0, dead counter=0.
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
- All outputs are registered and decoded from the state register:
  - pg_n = (state!=HIGH)
  - ng = (state==LOW)
  - busy = (state==DEAD_H or DEAD_L)
- Invariant: pg_n==0 and ng==1 never occur in the same cycle, including through reset and en toggles.
- States: OFF, DEAD_H, DEAD_L, HIGH, LOW.
- Effective dead time: D = max(dead_time,1). On entry to DEAD_x the counter loads D-1.
- OFF:
  - en=1 and req=1 -> DEAD_H
  - en=1 and req=0 -> DEAD_L
  - otherwise stay in OFF
- DEAD_H / DEAD_L:
  - Counter decrements each cycle. When counter==0 -> HIGH (from DEAD_H) or LOW (from DEAD_L), and trans_cnt increments.
  - Each dead state therefore lasts exactly D cycles.
  - req flips during dead: switch to the other DEAD state on the next edge and keep counting without reloading. Both devices have been off since entry, so the remaining count is safe.
- HIGH: req=0 -> DEAD_L with counter reload. LOW: req=1 -> DEAD_H with counter reload. Otherwise hold.
- en=0 has priority over everything except rst. From any state, go to OFF on the next edge and clear the counter; turning devices off is always safe.
- Latency:
  - req changes before edge k (state HIGH or LOW) -> both gates off from edge k.
  - The opposite device turns on at edge k+D.
  - Turn-off latency is 1 cycle.
- Mid-operation events:
  - rst or en=0 during a dead interval aborts it. Re-enabling starts a full new dead interval from OFF.
  - dead_time changes mid-interval are ignored until the next load.
- trans_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package cmos_ctrl_pkg:
  - state enum with codes OFF=0, DEAD_H=1, DEAD_L=2, HIGH=3, LOW=4
  - DT_MIN=1
  - default DT_W and CNT_W
- One sub-module: deadtime_counter. It takes load, load value and decrement inputs and provides a zero output. The FSM and gate decode stay in the top module.

Test Plan:
- Reset/enable: rst=1 for 2 cycles with en=1 -> pg_n=1, ng=0, state=OFF, trans_cnt=0. Release with en=1, req=0, dead_time=3 -> busy for 3 cycles, then ng=1 and trans_cnt=1.
- Handover: in LOW, raise req at edge k with dead_time=4 -> ng=0 at k, pg_n=1 for edges k..k+3, pg_n=0 at k+4, trans_cnt increments by 1.
- Zero dead time: dead_time=0 and req toggles -> exactly 1 cycle with both off (D=1).
- Reversal in dead: enter DEAD_H with D=5, flip req back to 0 after 2 cycles -> state becomes DEAD_L, and ng=1 at the originally scheduled edge (5 cycles after entry).
- Abort: en=0 during DEAD_H, then en=1 with req=1 next cycle -> OFF for 1 cycle, then a full D-cycle dead interval, then pg_n=0. rst mid-HIGH -> pg_n=1 on the next edge.
- Random stress: 10k cycles of random req, en, dead_time and occasional rst -> assertion never (pg_n==0 && ng==1), and every turn-on is preceded by at least D off cycles.

Source files
------------

// File: rtl/cmos_ctrl_pkg.sv
// Shared definitions for the CMOS output-pair gate sequencer.
package cmos_ctrl_pkg;

   localparam int DT_W_DEF  = 4;
   localparam int CNT_W_DEF = 8;

   // Shortest dead interval allowed; dead_time = 0 still keeps both gates off for one cycle.
   localparam int DT_MIN = 1;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_DEAD_H = 3'd1,
      ST_DEAD_L = 3'd2,
      ST_HIGH   = 3'd3,
      ST_LOW    = 3'd4
   } state_t;

endpackage

// File: rtl/cmos_pair_deadtime_ctrl_deadtime_counter.sv
// Down-counter timing the break-before-make interval; zero marks terminal count.
module deadtime_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic [W-1:0] count
);

   // Clear has priority over load, load over decrement; never underflows.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cmos_pair_deadtime_ctrl.sv
// Break-before-make gate sequencer for a PMOS pull-up / NMOS pull-down pair.
//
// state  | meaning
// -------+---------------------------------------------------------------
// OFF    | disabled or just reset; both devices off, output floats
// DEAD_H | both off, timing dead interval before PMOS turn-on
// DEAD_L | both off, timing dead interval before NMOS turn-on
// HIGH   | PMOS on (pg_n=0), NMOS off
// LOW    | NMOS on (ng=1), PMOS off
//
// Gate outputs are decoded from the next state and registered together with
// the state, so pg_n=0 and ng=1 can only appear in HIGH and LOW respectively
// and are therefore mutually exclusive in every cycle.
module cmos_pair_deadtime_ctrl
   import cmos_ctrl_pkg::*;
#(
   parameter int DT_W  = DT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req,
   input  logic [DT_W-1:0]  dead_time,
   output logic             pg_n,
   output logic             ng,
   output logic [2:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] trans_cnt
);

   state_t            state_q;
   state_t            state_nxt;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_clr;
   logic              cnt_zero;
   logic [DT_W-1:0]   cnt_val;
   logic [DT_W-1:0]   dead_eff;
   logic [DT_W-1:0]   load_val;
   logic              turn_on;

   // Effective dead time is clamped to DT_MIN; the counter holds D-1 so the
   // dead state lasts exactly D cycles including the entry cycle.
   always_comb begin
      if (dead_time < DT_W'(DT_MIN)) begin
         dead_eff = DT_W'(DT_MIN);
      end else begin
         dead_eff = dead_time;
      end
      load_val = dead_eff - DT_W'(1);
   end

   // Next-state and counter control; a reversal inside a dead interval swaps
   // direction without reloading because both devices are already off.
   always_comb begin
      state_nxt = state_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_clr   = 1'b0;
      turn_on   = 1'b0;
      if (!en) begin
         state_nxt = ST_OFF;
         cnt_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_OFF: begin
               cnt_load  = 1'b1;
               state_nxt = req ? ST_DEAD_H : ST_DEAD_L;
            end
            ST_HIGH: begin
               if (!req) begin
                  cnt_load  = 1'b1;
                  state_nxt = ST_DEAD_L;
               end
            end
            ST_LOW: begin
               if (req) begin
                  cnt_load  = 1'b1;
                  state_nxt = ST_DEAD_H;
               end
            end
            ST_DEAD_H, ST_DEAD_L: begin
               if (cnt_zero) begin
                  turn_on   = 1'b1;
                  state_nxt = req ? ST_HIGH : ST_LOW;
               end else begin
                  cnt_dec   = 1'b1;
                  state_nxt = req ? ST_DEAD_H : ST_DEAD_L;
               end
            end
            default: begin
               state_nxt = ST_OFF;
               cnt_clr   = 1'b1;
            end
         endcase
      end
   end

   deadtime_counter #(
      .W (DT_W)
   ) u_dead_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .count    (cnt_val)
   );

   // State register with registered gate/status decode and turn-on counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_OFF;
         pg_n      <= 1'b1;
         ng        <= 1'b0;
         busy      <= 1'b0;
         trans_cnt <= '0;
      end else begin
         state_q   <= state_nxt;
         pg_n      <= (state_nxt != ST_HIGH);
         ng        <= (state_nxt == ST_LOW);
         busy      <= (state_nxt == ST_DEAD_H) || (state_nxt == ST_DEAD_L);
         if (turn_on) begin
            trans_cnt <= trans_cnt + CNT_W'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_cmos_pair_deadtime_ctrl.sv
// Directed and randomised checks for the CMOS pair dead-time controller.
module tb_cmos_pair_deadtime_ctrl;

   logic       clk;
   logic       rst;
   logic       en;
   logic       req;
   logic [3:0] dead_time;
   logic       pg_n;
   logic       ng;
   logic [2:0] state;
   logic       busy;
   logic [7:0] trans_cnt;

   int checks;
   int errors;

   cmos_pair_deadtime_ctrl #(
      .DT_W  (4),
      .CNT_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .dead_time (dead_time),
      .pg_n      (pg_n),
      .ng        (ng),
      .state     (state),
      .busy      (busy),
      .trans_cnt (trans_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int   dead_run;
      int   d_entry;
      int   dt_applied;
      logic prev_busy;
      logic prev_pg_n;
      logic prev_ng;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      en        = 1'b1;
      req       = 1'b0;
      dead_time = 4'd3;

      // Reset held two cycles with en=1
      tick(2);
      check("rst_state", 32'(state), 32'd0);
      check("rst_pg_n", 32'(pg_n), 32'd1);
      check("rst_ng", 32'(ng), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trans", 32'(trans_cnt), 32'd0);

      // Release: OFF -> DEAD_L for 3 cycles -> LOW
      rst = 1'b0;
      tick(1);
      check("en_dead_state", 32'(state), 32'd2);
      for (int i = 0; i < 3; i++) begin
         check("en_dead_busy", 32'(busy), 32'd1);
         check("en_dead_ng", 32'(ng), 32'd0);
         tick(1);
      end
      check("en_low_ng", 32'(ng), 32'd1);
      check("en_low_busy", 32'(busy), 32'd0);
      check("en_low_trans", 32'(trans_cnt), 32'd1);

      // Handover LOW -> HIGH with dead_time=4
      req       = 1'b1;
      dead_time = 4'd4;
      tick(1);
      check("ho_ng_off", 32'(ng), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("ho_pg_off", 32'(pg_n), 32'd1);
         check("ho_state", 32'(state), 32'd1);
         if (i < 3) tick(1);
      end
      tick(1);
      check("ho_pg_on", 32'(pg_n), 32'd0);
      check("ho_trans", 32'(trans_cnt), 32'd2);

      // Zero dead time behaves as one cycle
      dead_time = 4'd0;
      req       = 1'b0;
      tick(1);
      check("dt0_both_off", 32'({pg_n, ng}), 32'b10);
      tick(1);
      check("dt0_low", 32'(state), 32'd4);
      check("dt0_trans", 32'(trans_cnt), 32'd3);
      req = 1'b1;
      tick(1);
      check("dt0_both_off2", 32'({pg_n, ng}), 32'b10);
      tick(1);
      check("dt0_high", 32'(pg_n), 32'd0);
      check("dt0_trans2", 32'(trans_cnt), 32'd4);

      // Back to LOW with D=1, then reversal inside a D=5 DEAD_H
      req       = 1'b0;
      dead_time = 4'd1;
      tick(2);
      check("rev_pre_low", 32'(state), 32'd4);
      dead_time = 4'd5;
      req       = 1'b1;
      tick(1);
      check("rev_dead_h", 32'(state), 32'd1);
      tick(1);
      req       = 1'b0;
      dead_time = 4'd1;
      tick(1);
      check("rev_dead_l", 32'(state), 32'd2);
      tick(2);
      check("rev_still_busy", 32'(busy), 32'd1);
      check("rev_ng_still_off", 32'(ng), 32'd0);
      tick(1);
      check("rev_ng_on", 32'(ng), 32'd1);
      check("rev_trans", 32'(trans_cnt), 32'd6);

      // Abort with en=0 during DEAD_H, then a full fresh interval
      dead_time = 4'd3;
      req       = 1'b1;
      tick(1);
      check("ab_dead_h", 32'(state), 32'd1);
      en = 1'b0;
      tick(1);
      check("ab_off", 32'(state), 32'd0);
      check("ab_off_busy", 32'(busy), 32'd0);
      en = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         check("ab_dead_busy", 32'(busy), 32'd1);
         check("ab_dead_pg", 32'(pg_n), 32'd1);
         tick(1);
      end
      check("ab_pg_on", 32'(pg_n), 32'd0);
      check("ab_trans", 32'(trans_cnt), 32'd7);

      // Reset while HIGH
      rst = 1'b1;
      tick(1);
      check("rh_pg_n", 32'(pg_n), 32'd1);
      check("rh_state", 32'(state), 32'd0);
      check("rh_trans", 32'(trans_cnt), 32'd0);
      rst = 1'b0;
      en  = 1'b0;
      tick(1);

      // trans_cnt wraps after 256 turn-ons
      en        = 1'b1;
      dead_time = 4'd0;
      for (int i = 0; i < 256; i++) begin
         req = i[0];
         tick(2);
         if (i == 254) check("wrap_255", 32'(trans_cnt), 32'd255);
      end
      check("wrap_0", 32'(trans_cnt), 32'd0);
      check("wrap_high", 32'(pg_n), 32'd0);

      // Random stress: no shoot-through, every turn-on after exactly D dead cycles
      rst = 1'b1;
      tick(1);
      rst        = 1'b0;
      dead_run   = 0;
      d_entry    = 1;
      prev_busy  = 1'b0;
      prev_pg_n  = 1'b1;
      prev_ng    = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         en  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) req = ~req;
         if ($urandom_range(0, 5) == 0) dead_time = 4'($urandom_range(0, 15));
         dt_applied = int'(dead_time);
         tick(1);
         check("no_shoot", 32'(!(pg_n == 1'b0 && ng == 1'b1)), 32'd1);
         if (busy) begin
            if (prev_busy) begin
               dead_run++;
            end else begin
               dead_run = 1;
               d_entry  = (dt_applied < 1) ? 1 : dt_applied;
            end
         end
         if ((!pg_n && prev_pg_n) || (ng && !prev_ng)) begin
            check("stress_from_dead", 32'(prev_busy), 32'd1);
            check("stress_dead_len", 32'(dead_run), 32'(d_entry));
         end
         prev_busy = busy;
         prev_pg_n = pg_n;
         prev_ng   = ng;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
